// File: rtl/posit_ext_sched.sv
// Round-robin issue scheduler sharing one posit extraction datapath, with a credit-protected
// response FIFO and drain/flush handshake. Define PEXT_SCHED_PERF_EN for issue/stall counters.
module posit_ext_sched #(
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_data,
    input  logic [2*NREQ-1:0]       req_mode,
    output logic [31:0]             ext_in,
    output logic [1:0]              ext_mode,
    input  logic [3:0]              ext_s,
    input  logic [15:0]             ext_rg_exp,
    input  logic [27:0]             ext_mant,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [1:0]              rsp_mode,
    output logic [3:0]              rsp_s,
    output logic [15:0]             rsp_rg_exp,
    output logic [27:0]             rsp_mant,
    output logic                    err_valid,
    output logic [$clog2(NREQ)-1:0] err_id,
    input  logic                    flush_req,
    output logic                    flush_done
`ifdef PEXT_SCHED_PERF_EN
    ,
    output logic [15:0]             perf_issued,
    output logic [15:0]             perf_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EW  = IDW + 2 + 4 + 16 + 28;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    logic [1:0]     state;
    logic           live;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic [31:0]    grant_data;
    logic [1:0]     grant_mode;
    logic           accept_legal;
    logic           accept_illegal;

    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id   [LAT];
    logic [1:0]     tag_mode [LAT];

    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight_count;
    logic [CW:0]    used_count;
    logic           credit_ok;
    logic           fifo_push;
    logic           fifo_pop;
    logic           drained;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_count = inflight_count + CW'(tag_v[i]);
        end
    end

    // A pop in the current cycle deliberately does not return credit until it is registered.
    assign used_count = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign credit_ok  = used_count < (CW + 1)'(DEPTH);
    assign drained    = (inflight_count == '0) && (fifo_count == '0);

    // live stays low through reset so req_ready never follows the raw reset net.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        if (live && state == ST_RUN && credit_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'((int'(rr_ptr) + k) % NREQ);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign grant_data     = req_data[32*int'(grant_id) +: 32];
    assign grant_mode     = req_mode[2*int'(grant_id) +: 2];
    assign accept_legal   = grant_found && (grant_mode != MODE_ILLEGAL);
    assign accept_illegal = grant_found && (grant_mode == MODE_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            live       <= 1'b0;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
        end else begin
            live       <= 1'b1;
            flush_done <= (state == ST_DRAIN) && drained;
            if (grant_found) begin
                rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            case (state)
                ST_RUN:   if (flush_req) state <= ST_DRAIN;
                ST_DRAIN: if (drained)   state <= ST_DONE;
                ST_DONE:  if (!flush_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_in    <= '0;
            ext_mode  <= '0;
            err_valid <= 1'b0;
            err_id    <= '0;
        end else begin
            err_valid <= accept_illegal;
            if (accept_illegal) begin
                err_id <= grant_id;
            end
            if (accept_legal) begin
                ext_in   <= grant_data;
                ext_mode <= grant_mode;
            end
        end
    end

    // Tags walk alongside the datapath so each result is captured exactly LAT cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i]   <= '0;
                tag_mode[i] <= '0;
            end
        end else begin
            tag_v[0]    <= accept_legal;
            tag_id[0]   <= grant_id;
            tag_mode[0] <= grant_mode;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_id[i]   <= tag_id[i-1];
                tag_mode[i] <= tag_mode[i-1];
            end
        end
    end

    assign fifo_push = tag_v[LAT-1];
    assign rsp_valid = (fifo_count != '0);
    assign fifo_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= {tag_id[LAT-1], tag_mode[LAT-1], ext_s, ext_rg_exp, ext_mant};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    assign {rsp_id, rsp_mode, rsp_s, rsp_rg_exp, rsp_mant} = fifo_mem[rd_ptr];

`ifdef PEXT_SCHED_PERF_EN
    logic stall_cycle;
    assign stall_cycle = (state == ST_RUN) && (|req_valid) && (req_ready == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept_legal && perf_issued != 16'hFFFF) begin
                perf_issued <= perf_issued + 16'd1;
            end
            if (stall_cycle && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`else
    // Without the counters no extra state is built.
`endif

endmodule
